dma_blit: RTL and testbench
===========================

Name: dma_blit

Overview:
- Parametrised second-generation 2D DMA/blitter for the dd8 video/memory bus.
- The CPU programs source, destination, row width, column count and control through a byte-wide register port.
- The engine then copies, or optionally fills, a rectangular block using {col, row} 2D addressing.
- It only drives the shared bus while `bus_grant` (the VGA blanking window) is high, and pauses cleanly when it drops.

Parameters:
- ADDR_W, 17, op bus address width; must satisfy ROW_W < ADDR_W <= 24.
- ROW_W, 8, row (low) address field width; `row_width` register width; 1..16.
- COL_W, ADDR_W-ROW_W, column (high) field width; `cols_number` register width; 1..16.
- DATA_W, 8, op bus data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- reg_sel  in  4  register select.
- reg_data  in  8  register write data.
- reg_we  in  1  register write strobe, sampled on posedge clk.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes or is aborted.
- bus_grant  in  1  op bus available (VGA blank).
- op_addr  out  ADDR_W  bus address.
- op_data_in  in  DATA_W  read data.
- op_data_out  out  DATA_W  write data.
- op_data_oe  out  1  `op_data_out` drive enable; the top level builds the tristate.
- op_re  out  1  read strobe.
- op_we  out  1  write strobe.

Behaviour:
- Reset: all registers 0, FSM IDLE; busy=0, done=0, op_re=0, op_we=0, op_data_oe=0, op_addr=0, op_data_out=0.
- Register map (byte writes, little-endian):
  - 0-2 src[23:0]; 3-5 dst[23:0]; bits above ADDR_W are discarded.
  - 6-7 row_width[15:0] and 8-9 cols_number[15:0], truncated to ROW_W / COL_W.
  - A ctrl: bit0 dir, bit1 start, bit2 fill, bit4 abort.
  - B fill_value (zero-extended to DATA_W).
  - C-F ignored.
- Register writes are ignored while busy, except a ctrl write with bit4=1.
- Abort: goes to IDLE next cycle, pulses done, and does not write the element in flight.
- FSM states: IDLE, READ, WRITE.
  - IDLE + ctrl write with start=1 -> if row_width==0 or cols_number==0, pulse done next cycle and stay IDLE; else latch counters row_cnt=0, col_cnt=0, busy=1, go to READ (WRITE if fill).
  - READ (bus_grant=1): op_re=1, op_addr=src address; capture op_data_in into tmp at posedge; go to WRITE.
  - WRITE (bus_grant=1): op_we=1, op_data_oe=1, op_addr=dst address, op_data_out=tmp (fill_value if fill); advance counters; go to READ (or WRITE if fill), or IDLE after the last element.
  - bus_grant=0 in any non-IDLE state: all strobes and oe low, state and counters frozen, op_addr holds its last value.
- Element offset:
  - dir=0: r=row_cnt, c=col_cnt.
  - dir=1: r=row_width-1-row_cnt, c=cols_number-1-col_cnt (for overlapping moves).
- Address: {base_col + c, base_row + r}.
  - Row field is ROW_W wide and wraps modulo 2^ROW_W with no carry into the column field.
  - Column field wraps modulo 2^COL_W.
- Counter advance: row_cnt+1; at row_width, row_cnt=0 and col_cnt+1. Last element is (row_width-1, cols_number-1).
- Completion: the cycle after the last WRITE, busy=0 and done=1 for exactly one cycle.
- Throughput with grant held: copy = 2 cycles/element; fill = 1 cycle/element. Latency from the start-write edge to the first strobe is 1 cycle.
- Simultaneous events:
  - rst wins over everything.
  - A start write on the same cycle a transfer completes is ignored (busy still 1 at that edge).
  - A grant drop between READ and WRITE keeps tmp valid.

Optional Feature:
- DMA_BLIT_FILL_EN defined: ctrl bit2 selects fill mode as described.
- Not defined: bit2 is ignored, fill_value register is absent, all transfers are copies (READ/WRITE alternation only).

Test Plan:
- Copy forward: src=0x00010, dst=0x10020, row_width=4, cols_number=2, grant=1 -> reads 0x00010-13 then 0x00110-13; writes 0x10020-23 then 0x10120-23 with the matching data; 16 cycles of busy; one done pulse.
- Backward overlap: src=0x0000, dst=0x0001, row_width=4, cols=1, dir=1, memory 11,22,33,44 -> final 11,11,22,33,44 at 0x0000-4.
- Grant stall: same as the first scenario, grant low for 5 cycles after the 3rd read -> no strobes while low, tmp retained, resulting memory identical, busy duration +5.
- Row wrap: src row=0xFE, row_width=4, ROW_W=8 -> source rows FE, FF, 00, 01, column field unchanged.
- Fill (macro on): dst=0x0200, fill_value=0xA5, 3x3 -> 9 writes of A5, no op_re, 9 busy cycles. Macro off: same setup performs a copy.
- Edge: row_width=0 start -> done pulse, no strobes. Abort mid-transfer -> IDLE next cycle, done pulse. Reg writes while busy (non-abort) -> ignored. rst mid-transfer -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dma_blit.sv
// 2D copy/fill blitter for the dd8 op bus, driving the bus only while bus_grant is high.
// Optional macro DMA_BLIT_FILL_EN enables fill mode (ctrl bit2 plus the fill_value register).
module dma_blit #(
  parameter int ADDR_W = 17,
  parameter int ROW_W  = 8,
  parameter int COL_W  = ADDR_W - ROW_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        reg_sel,
  input  logic [7:0]        reg_data,
  input  logic              reg_we,
  output logic              busy,
  output logic              done,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_data_in,
  output logic [DATA_W-1:0] op_data_out,
  output logic              op_data_oe,
  output logic              op_re,
  output logic              op_we
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q;
  logic [ROW_W-1:0]  roww_q, roww_d, row_cnt_q, row_cnt_d, r_off;
  logic [COL_W-1:0]  cols_q, cols_d, col_cnt_q, col_cnt_d, c_off;
  logic [DATA_W-1:0] tmp_q, tmp_d, wdata;
  logic              dir_q, dir_d, done_q, done_d;
  logic              fill, fill_start;
  logic              ctrl_wr, cfg_we, abort, last;
  logic [ADDR_W-1:0] src_addr, dst_addr;

`ifdef DMA_BLIT_FILL_EN
  logic       fill_q, fill_d;
  logic [7:0] fillv_q, fillv_d;
  assign fill       = fill_q;
  assign fill_start = reg_data[2];
  assign wdata      = fill_q ? DATA_W'(fillv_q) : tmp_q;
`else
  assign fill       = 1'b0;
  assign fill_start = 1'b0;
  assign wdata      = tmp_q;
`endif

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign ctrl_wr = reg_we && (reg_sel == 4'hA);
  assign abort   = ctrl_wr && reg_data[4] && busy;
  assign cfg_we  = reg_we && !busy;

  // dir=1 walks the block from its far corner so overlapping moves stay correct
  assign r_off = dir_q ? (roww_q - ROW_W'(1) - row_cnt_q) : row_cnt_q;
  assign c_off = dir_q ? (cols_q - COL_W'(1) - col_cnt_q) : col_cnt_q;

  // row and column fields wrap independently, no carry between them
  assign src_addr = {src_q[ADDR_W-1:ROW_W] + c_off, src_q[ROW_W-1:0] + r_off};
  assign dst_addr = {dst_q[ADDR_W-1:ROW_W] + c_off, dst_q[ROW_W-1:0] + r_off};
  assign last     = (row_cnt_q == roww_q - ROW_W'(1)) && (col_cnt_q == cols_q - COL_W'(1));

  always_comb begin
    op_re       = (state_q == S_READ) && bus_grant && !abort;
    op_we       = (state_q == S_WRITE) && bus_grant && !abort;
    op_data_oe  = op_we;
    op_data_out = op_we ? wdata : '0;
    if ((state_q == S_READ) && bus_grant)       op_addr = src_addr;
    else if ((state_q == S_WRITE) && bus_grant) op_addr = dst_addr;
    else                                        op_addr = addr_q;
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    roww_d    = roww_q;
    cols_d    = cols_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    tmp_d     = tmp_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
`ifdef DMA_BLIT_FILL_EN
    fill_d    = fill_q;
    fillv_d   = fillv_q;
    if (cfg_we && reg_sel == 4'hB) fillv_d = reg_data;
    if (cfg_we && ctrl_wr)         fill_d  = reg_data[2];
`endif
    // byte-lane register writes; bits beyond each field width are dropped
    for (int i = 0; i < ADDR_W; i++) begin
      if (cfg_we && reg_sel == 4'(i / 8))     src_d[i] = reg_data[i % 8];
      if (cfg_we && reg_sel == 4'(3 + i / 8)) dst_d[i] = reg_data[i % 8];
    end
    for (int i = 0; i < ROW_W; i++)
      if (cfg_we && reg_sel == 4'(6 + i / 8)) roww_d[i] = reg_data[i % 8];
    for (int i = 0; i < COL_W; i++)
      if (cfg_we && reg_sel == 4'(8 + i / 8)) cols_d[i] = reg_data[i % 8];
    if (cfg_we && ctrl_wr) dir_d = reg_data[0];

    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (ctrl_wr && reg_data[1]) begin
          if (roww_q == '0 || cols_q == '0) done_d = 1'b1;
          else begin
            row_cnt_d = '0;
            col_cnt_d = '0;
            state_d   = fill_start ? S_WRITE : S_READ;
          end
        end
        S_READ: if (bus_grant) begin
          tmp_d   = op_data_in;
          state_d = S_WRITE;
        end
        S_WRITE: if (bus_grant) begin
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = fill ? S_WRITE : S_READ;
            if (row_cnt_q == roww_q - ROW_W'(1)) begin
              row_cnt_d = '0;
              col_cnt_d = col_cnt_q + COL_W'(1);
            end else begin
              row_cnt_d = row_cnt_q + ROW_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      roww_q    <= '0;
      cols_q    <= '0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      tmp_q     <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
`ifdef DMA_BLIT_FILL_EN
      fill_q    <= 1'b0;
      fillv_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      roww_q    <= roww_d;
      cols_q    <= cols_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      tmp_q     <= tmp_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      addr_q    <= op_addr;
`ifdef DMA_BLIT_FILL_EN
      fill_q    <= fill_d;
      fillv_q   <= fillv_d;
`endif
    end
  end
endmodule

// File: tb/tb_dma_blit.sv
// Directed bench for dma_blit with a byte memory model on the op bus.
module tb_dma_blit;
  logic        clk = 1'b0;
  logic        rst, reg_we, bus_grant, busy, done, op_data_oe, op_re, op_we;
  logic [3:0]  reg_sel;
  logic [7:0]  reg_data, op_data_in, op_data_out;
  logic [16:0] op_addr;

  logic [7:0]  mem [0:(1<<17)-1];
  logic [16:0] rd_q[$], wr_q[$];
  int          busy_n = 0, done_n = 0, viol_n = 0;
  int          b_busy, b_done, b_viol, b_rd, b_wr;
  int          errs = 0, checks = 0;
  logic        pl_we = 1'b0;
  logic [16:0] pl_addr;
  logic [7:0]  pl_data;

  dma_blit dut (
    .clk(clk), .rst(rst), .reg_sel(reg_sel), .reg_data(reg_data), .reg_we(reg_we),
    .busy(busy), .done(done), .bus_grant(bus_grant), .op_addr(op_addr),
    .op_data_in(op_data_in), .op_data_out(op_data_out), .op_data_oe(op_data_oe),
    .op_re(op_re), .op_we(op_we)
  );

  always #5 clk = ~clk;
  assign op_data_in = mem[op_addr];

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (op_re) rd_q.push_back(op_addr);
    if (op_we) begin
      wr_q.push_back(op_addr);
      mem[op_addr] <= op_data_out;
    end
    if (busy) busy_n <= busy_n + 1;
    if (done) done_n <= done_n + 1;
    if (!bus_grant && (op_re || op_we || op_data_oe)) viol_n <= viol_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    reg_sel = s; reg_data = d; reg_we = 1'b1;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic pl(input logic [16:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic cfg(input logic [23:0] s, input logic [23:0] d, input logic [15:0] rw, input logic [15:0] c);
    wr(4'h0, s[7:0]);  wr(4'h1, s[15:8]); wr(4'h2, s[23:16]);
    wr(4'h3, d[7:0]);  wr(4'h4, d[15:8]); wr(4'h5, d[23:16]);
    wr(4'h6, rw[7:0]); wr(4'h7, rw[15:8]);
    wr(4'h8, c[7:0]);  wr(4'h9, c[15:8]);
  endtask

  task automatic mark();
    b_busy = busy_n; b_done = done_n; b_viol = viol_n;
    b_rd = rd_q.size(); b_wr = wr_q.size();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; reg_we = 1'b0; reg_sel = '0; reg_data = '0; bus_grant = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_flags", {27'd0, busy, done, op_re, op_we, op_data_oe}, 32'd0);
    chk("rst_addr", op_addr, 32'd0);
    chk("rst_dout", op_data_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // forward copy 4x2
    for (int i = 0; i < 4; i++) begin
      pl(17'h00010 + 17'(i), 8'(8'h01 + i));
      pl(17'h00110 + 17'(i), 8'(8'h50 + i));
    end
    cfg(24'h000010, 24'h010020, 16'd4, 16'd2);
    mark();
    wr(4'hA, 8'h02);
    chk("fwd_lat_re", {31'd0, op_re}, 32'd1);
    chk("fwd_lat_addr", op_addr, 32'h10);
    wait_idle();
    chk("fwd_busy", busy_n - b_busy, 32'd16);
    chk("fwd_done", done_n - b_done, 32'd1);
    chk("fwd_nrd", rd_q.size() - b_rd, 32'd8);
    chk("fwd_nwr", wr_q.size() - b_wr, 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk("fwd_rd", rd_q[b_rd + k], 32'h10 + (k / 4) * 32'h100 + k % 4);
      chk("fwd_wr", wr_q[b_wr + k], 32'h10020 + (k / 4) * 32'h100 + k % 4);
    end
    for (int i = 0; i < 4; i++) begin
      chk("fwd_mem0", mem[17'h10020 + 17'(i)], 32'h01 + i);
      chk("fwd_mem1", mem[17'h10120 + 17'(i)], 32'h50 + i);
    end

    // backward overlapping move by one byte
    pl(17'h0, 8'h11); pl(17'h1, 8'h22); pl(17'h2, 8'h33); pl(17'h3, 8'h44); pl(17'h4, 8'h00);
    cfg(24'h0, 24'h1, 16'd4, 16'd1);
    mark();
    wr(4'hA, 8'h03);
    wait_idle();
    chk("bwd_rd0", rd_q[b_rd], 32'h3);
    chk("bwd_m0", mem[0], 32'h11);
    chk("bwd_m1", mem[1], 32'h11);
    chk("bwd_m2", mem[2], 32'h22);
    chk("bwd_m3", mem[3], 32'h33);
    chk("bwd_m4", mem[4], 32'h44);

    // grant stall after the third read
    for (int i = 0; i < 4; i++) begin
      pl(17'h10020 + 17'(i), 8'h00);
      pl(17'h10120 + 17'(i), 8'h00);
    end
    cfg(24'h000010, 24'h010020, 16'd4, 16'd2);
    mark();
    wr(4'hA, 8'h02);
    for (int n = 0; n < 50 && (rd_q.size() - b_rd) < 3; n++) @(negedge clk);
    chk("stall_reach", rd_q.size() - b_rd, 32'd3);
    bus_grant = 1'b0;
    #1;
    chk("stall_hold_addr", op_addr, 32'h12);
    chk("stall_strobes", {29'd0, op_re, op_we, op_data_oe}, 32'd0);
    repeat (5) @(negedge clk);
    bus_grant = 1'b1;
    wait_idle();
    chk("stall_busy", busy_n - b_busy, 32'd21);
    chk("stall_viol", viol_n - b_viol, 32'd0);
    chk("stall_nwr", wr_q.size() - b_wr, 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk("stall_mem0", mem[17'h10020 + 17'(i)], 32'h01 + i);
      chk("stall_mem1", mem[17'h10120 + 17'(i)], 32'h50 + i);
    end

    // row field wraps without touching the column field
    cfg(24'h0000FE, 24'h001000, 16'd4, 16'd1);
    mark();
    wr(4'hA, 8'h02);
    wait_idle();
    chk("wrap_rd0", rd_q[b_rd], 32'h0FE);
    chk("wrap_rd1", rd_q[b_rd + 1], 32'h0FF);
    chk("wrap_rd2", rd_q[b_rd + 2], 32'h000);
    chk("wrap_rd3", rd_q[b_rd + 3], 32'h001);

    // fill request (copy when fill support is compiled out)
    for (int i = 0; i < 9; i++) pl(17'h00500 + 17'((i / 3) * 256 + i % 3), 8'(8'h60 + i));
    wr(4'hB, 8'hA5);
    cfg(24'h000500, 24'h000200, 16'd3, 16'd3);
    mark();
    wr(4'hA, 8'h06);
    wait_idle();
    chk("fill_nwr", wr_q.size() - b_wr, 32'd9);
`ifdef DMA_BLIT_FILL_EN
    chk("fill_busy", busy_n - b_busy, 32'd9);
    chk("fill_nrd", rd_q.size() - b_rd, 32'd0);
    for (int i = 0; i < 9; i++)
      chk("fill_mem", mem[17'h00200 + 17'((i / 3) * 256 + i % 3)], 32'hA5);
`else
    chk("fill_busy", busy_n - b_busy, 32'd18);
    chk("fill_nrd", rd_q.size() - b_rd, 32'd9);
    for (int i = 0; i < 9; i++)
      chk("fill_mem", mem[17'h00200 + 17'((i / 3) * 256 + i % 3)], 32'h60 + i);
`endif

    // zero-size start
    wr(4'h6, 8'h00); wr(4'h7, 8'h00);
    mark();
    wr(4'hA, 8'h02);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("zero_strobes", (rd_q.size() - b_rd) + (wr_q.size() - b_wr), 32'd0);
    chk("zero_done_n", done_n - b_done, 32'd1);

    // abort lands on the second WRITE cycle
    cfg(24'h000010, 24'h010020, 16'd4, 16'd2);
    mark();
    wr(4'hA, 8'h02);
    repeat (3) @(negedge clk);
    wr(4'hA, 8'h10);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("abort_nwr", wr_q.size() - b_wr, 32'd1);
    chk("abort_done_n", done_n - b_done, 32'd1);

    // non-abort writes while busy are ignored
    mark();
    wr(4'hA, 8'h02);
    wr(4'h0, 8'h77);
    wr(4'h6, 8'h01);
    wr(4'hA, 8'h03);
    wait_idle();
    chk("ign_nrd", rd_q.size() - b_rd, 32'd8);
    chk("ign_nwr", wr_q.size() - b_wr, 32'd8);
    chk("ign_last_rd", rd_q[rd_q.size() - 1], 32'h113);
    chk("ign_done_n", done_n - b_done, 32'd1);

    // reset mid-transfer
    wr(4'hA, 8'h02);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_flags", {27'd0, busy, done, op_re, op_we, op_data_oe}, 32'd0);
    chk("mrst_addr", op_addr, 32'd0);
    chk("mrst_dout", op_data_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
